// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end: step FSM states and key indices.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } step_state_e;

  localparam int NUM_KEYS  = 3;
  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, registered active-high level, stability counter,
// debounced level and a one-cycle press pulse.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_down,
  output logic key_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_down_q, key_down_d;
  logic             key_press_q, key_press_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    level_d     = ~sync2_q;
    cnt_d       = '0;
    key_down_d  = key_down_q;
    key_press_d = 1'b0;
    if (level_q != key_down_q) begin
      if (cnt_q == CNT_LAST) begin
        key_down_d  = level_q;
        key_press_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      key_down_q  <= 1'b0;
      key_press_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      key_down_q  <= key_down_d;
      key_press_q <= key_press_d;
    end
  end

  assign key_down  = key_down_q;
  assign key_press = key_press_q;

endmodule

// File: rtl/key_input.sv
// Three debounced buttons, each feeding a press/hold/auto-repeat FSM that emits
// one-cycle step strobes aligned to frame boundaries.
module key_input
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                frame_tick,
  output logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press
);

  localparam logic [7:0] DELAY_LOAD  = 8'(REPEAT_DELAY);
  localparam logic [7:0] PERIOD_LOAD = 8'(REPEAT_PERIOD);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .key_n    (key_n[g]),
      .key_down (key_down[g]),
      .key_press(key_press[g])
    );
  end

  step_state_e         state_q [NUM_KEYS];
  step_state_e         state_d [NUM_KEYS];
  logic [7:0]          fcnt_q  [NUM_KEYS];
  logic [7:0]          fcnt_d  [NUM_KEYS];
  logic [NUM_KEYS-1:0] keys_q, keys_d;

  always_comb begin
    keys_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      fcnt_d[i]  = fcnt_q[i];
      // Release wins over a coincident frame_tick: no step on the way out.
      if (!key_down[i]) begin
        state_d[i] = IDLE;
        fcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          IDLE: if (key_press[i]) state_d[i] = ARMED;
          ARMED: if (frame_tick) begin
            keys_d[i]  = 1'b1;
            fcnt_d[i]  = DELAY_LOAD;
            state_d[i] = DELAY;
          end
          DELAY: if (frame_tick) begin
            if (fcnt_q[i] == 8'd1) begin
              keys_d[i]  = 1'b1;
              fcnt_d[i]  = PERIOD_LOAD;
              state_d[i] = REPEAT;
            end else begin
              fcnt_d[i] = fcnt_q[i] - 8'd1;
            end
          end
          REPEAT: if (frame_tick) begin
            if (fcnt_q[i] == 8'd1) begin
              keys_d[i] = 1'b1;
              fcnt_d[i] = PERIOD_LOAD;
            end else begin
              fcnt_d[i] = fcnt_q[i] - 8'd1;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      keys_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= IDLE;
        fcnt_q[i]  <= '0;
      end
    end else begin
      keys_q <= keys_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        fcnt_q[i]  <= fcnt_d[i];
      end
    end
  end

  assign keys = keys_q;

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input: DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2,
// frame_tick high in every cycle whose count is a multiple of 10.
module tb_key_input;

  logic       clk;
  logic       rst;
  logic [2:0] key_n;
  logic       frame_tick;
  logic [2:0] keys;
  logic [2:0] key_down;
  logic [2:0] key_press;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  key_input #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16),
    .REPEAT_DELAY   (3),
    .REPEAT_PERIOD  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .frame_tick(frame_tick),
    .keys      (keys),
    .key_down  (key_down),
    .key_press (key_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 ns after it, and frame_tick for the new cycle is set.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    frame_tick = (cyc % 10 == 0);
  endtask

  task automatic align(input int ph);
    for (int k = 0; k < 10 && (cyc % 10) != ph; k++) cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Strobe expected j cycles after a press made one cycle after a tick: ticks 1, 4, 6, 8, 10.
  function automatic logic exp_step(input int j);
    int k;
    k = j / 10;
    return (j % 10 == 0) && (k == 1 || (k >= 4 && k % 2 == 0));
  endfunction

  task automatic test_reset();
    rst   = 1'b0;
    key_n = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if ({keys, key_down, key_press} !== 9'b0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 000000000", {keys, key_down, key_press});
      end
    end
    key_n = 3'b111;
    rst   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      total++;
      if (key_down !== 3'b000) begin
        bad++;
        $display("FAIL reset_idle_key_down: got %b want 000", key_down);
      end
    end
  endtask

  task automatic test_clean_press();
    key_n[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      total++;
      if (key_down[0] !== (i >= 6)) begin
        bad++;
        $display("FAIL press_key_down i=%0d: got %b want %b", i, key_down[0], (i >= 6));
      end
      total++;
      if (key_press[0] !== (i == 6)) begin
        bad++;
        $display("FAIL press_pulse i=%0d: got %b want %b", i, key_press[0], (i == 6));
      end
    end
    key_n[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      total++;
      if (key_down[0] !== (i < 6)) begin
        bad++;
        $display("FAIL release_key_down i=%0d: got %b want %b", i, key_down[0], (i < 6));
      end
      total++;
      if (key_press[0] !== 1'b0) begin
        bad++;
        $display("FAIL release_no_press i=%0d: got %b want 0", i, key_press[0]);
      end
    end
    idle(4);
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int seg = 0; seg < 10; seg++) begin
      key_n[1] = (seg % 2 == 1);
      for (int k = 0; k < 2; k++) begin
        cycle();
        total++;
        if (key_down[1] !== 1'b0 || key_press[1] !== 1'b0) begin
          bad++;
          $display("FAIL bounce_reject seg=%0d: down=%b press=%b want 0 0", seg, key_down[1],
                   key_press[1]);
        end
      end
    end
    key_n[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (key_press[1] === 1'b1) pulses++;
      total++;
      if (key_press[1] !== (i == 6)) begin
        bad++;
        $display("FAIL bounce_settle i=%0d: got %b want %b", i, key_press[1], (i == 6));
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL bounce_pulse_count: got %0d want 1", pulses);
    end
    key_n[1] = 1'b1;
    idle(12);
  endtask

  task automatic test_hold_repeat();
    align(1);
    key_n[2] = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      cycle();
      total++;
      if (keys !== {exp_step(j), 2'b00}) begin
        bad++;
        $display("FAIL hold_repeat j=%0d: got %b want %b", j, keys, {exp_step(j), 2'b00});
      end
    end
    key_n[2] = 1'b1;
    idle(12);
  endtask

  task automatic test_release_on_tick();
    align(1);
    key_n[0] = 1'b0;
    for (int j = 1; j <= 70; j++) begin
      cycle();
      total++;
      if (keys[0] !== (j == 10)) begin
        bad++;
        $display("FAIL release_on_tick_keys j=%0d: got %b want %b", j, keys[0], (j == 10));
      end
      if (j == 38 || j == 39) begin
        total++;
        if (key_down[0] !== (j == 38)) begin
          bad++;
          $display("FAIL release_on_tick_align j=%0d: got %b want %b", j, key_down[0], (j == 38));
        end
      end
      if (j == 32) key_n[0] = 1'b1;
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    align(1);
    key_n = 3'b010;
    for (int j = 1; j <= 70; j++) begin
      cycle();
      total++;
      if (keys !== {exp_step(j), 1'b0, exp_step(j)}) begin
        bad++;
        $display("FAIL simultaneous j=%0d: got %b want %b", j, keys,
                 {exp_step(j), 1'b0, exp_step(j)});
      end
    end
    key_n = 3'b111;
    idle(12);
  endtask

  task automatic test_reset_mid_hold();
    align(1);
    key_n[1] = 1'b0;
    for (int j = 1; j <= 59; j++) begin
      cycle();
      if (j == 40 || j == 50) begin
        total++;
        if (keys[1] !== (j == 40)) begin
          bad++;
          $display("FAIL mid_hold_repeat j=%0d: got %b want %b", j, keys[1], (j == 40));
        end
      end
    end
    rst = 1'b0;
    cycle();
    total++;
    if (keys !== 3'b000) begin
      bad++;
      $display("FAIL mid_hold_reset_keys: got %b want 000", keys);
    end
    total++;
    if (key_down !== 3'b000) begin
      bad++;
      $display("FAIL mid_hold_reset_down: got %b want 000", key_down);
    end
    total++;
    if (key_press !== 3'b000) begin
      bad++;
      $display("FAIL mid_hold_reset_press: got %b want 000", key_press);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      total++;
      if (key_press[1] !== (i == 6)) begin
        bad++;
        $display("FAIL mid_hold_repress i=%0d: got %b want %b", i, key_press[1], (i == 6));
      end
      total++;
      if (key_down[1] !== (i >= 6)) begin
        bad++;
        $display("FAIL mid_hold_redown i=%0d: got %b want %b", i, key_down[1], (i >= 6));
      end
    end
    key_n[1] = 1'b1;
    idle(12);
  endtask

  initial begin
    rst        = 1'b0;
    key_n      = 3'b111;
    frame_tick = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_release_on_tick();
    test_simultaneous();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_input.md
# key_input

Push-button front end for the game display: it turns the three raw, active-low, bouncing board buttons into clean per-frame movement strobes on `keys[2:0]`. It is the producer end of the `keys` interface the display consumes.

Each key is synchronized, debounced and then run through a press/hold/auto-repeat state machine. Step strobes are emitted only on frame boundaries, so the sprite moves at most one step per frame instead of one per clock.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles needed to accept a level change (1 ms at 50 MHz).
- `CNT_W`, default 16: width of the debounce counter; must hold `DEBOUNCE_CYCLES`.
- `REPEAT_DELAY`, default 8: frames between the first step and the first auto-repeat step; must be ≥1.
- `REPEAT_PERIOD`, default 1: frames between subsequent repeat steps; must be ≥1.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `key_n`, in, 3: raw buttons, asynchronous, 0 = pressed.
- `frame_tick`, in, 1: one-cycle pulse per frame, driven at the start of vertical blank.
- `keys`, out, 3: step strobes, one cycle high per step. Bit 0 = right, bit 1 = down, bit 2 = left.
- `key_down`, out, 3: debounced level, 1 = held.
- `key_press`, out, 3: one-cycle pulse on each debounced press.

## Operation
- **Sync:** a 2-flop synchronizer per bit, followed by inversion to active-high.
- **Debounce, per key:**
  - If the synced level equals `key_down`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES - 1` while the level still differs, `key_down` toggles on the next edge and the counter clears.
  - Any single-cycle agreement during counting restarts the count from 0.
- **`key_press[i]`:** high exactly in the first cycle `key_down[i]` reads 1.
- **Step FSM, one per key, states IDLE, ARMED, DELAY, REPEAT; 8-bit frame counter `fcnt`:**
  - IDLE: on the debounced press → ARMED. No step in that cycle, even if `frame_tick` is also high.
  - ARMED: on `frame_tick`, emit a step, load `fcnt = REPEAT_DELAY` → DELAY.
  - DELAY: on `frame_tick`:
    - if `fcnt == 1`, emit a step, load `fcnt = REPEAT_PERIOD` → REPEAT;
    - else decrement `fcnt`.
  - REPEAT: on `frame_tick`:
    - if `fcnt == 1`, emit a step and reload `REPEAT_PERIOD`;
    - else decrement `fcnt`.
  - Any state with `key_down[i] == 0` → IDLE and clears `fcnt`. Release beats `frame_tick` in the same cycle, so no step is emitted.
- Keys are fully independent. Several keys may strobe in the same cycle; resolving opposing keys is the consumer's job.
- `frame_tick` high for more than one cycle is treated as one event per high cycle; the source must not do this.

## Timing
- **Reset (`rst == 0` at a rising edge):**
  - all outputs 0;
  - synchronizers load 1 on `key_n` (i.e. released);
  - counters 0, FSMs IDLE.
  - Reset mid-debounce or mid-repeat discards all progress. A key still held after reset must re-debounce before it is accepted.
- **Press latency:** a raw edge first sampled at edge N sets `key_down` at edge N + 2 + `DEBOUNCE_CYCLES`. `key_press` is high in that same cycle.
- **Step latency:** `keys[i]` is registered and high in the cycle after the qualifying `frame_tick` cycle.
- **Release latency:** matches the press latency. The FSM returns to IDLE on the edge after `key_down` falls.
- **`fcnt` wrap:** cannot occur; the counter is reloaded at 1 and never decremented below 1.

## Structure
- **Shared package `key_pkg`:**
  - FSM state localparams: IDLE = 0, ARMED = 1, DELAY = 2, REPEAT = 3;
  - key index constants KEY_RIGHT = 0, KEY_DOWN = 1, KEY_LEFT = 2.
- **Sub-module `key_debounce`:** one key; contains the synchronizer, counter, `key_down` and `key_press`. It is instantiated three times. The step FSMs live in `key_input`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `REPEAT_DELAY = 3`, `REPEAT_PERIOD = 2`, and `frame_tick` every 10 cycles.
- **Clean press:** `key_n[0]` falls at cycle 0 → `key_down[0]` and `key_press[0]` rise at cycle 6. `key_press[0]` lasts exactly 1 cycle.
- **Bounce:** `key_n[1]` toggles every 2 cycles for 20 cycles, then stays low → no `key_press[1]` until 6 cycles after it settles. Exactly one pulse.
- **Hold repeat:** hold key 2 for 10 frames → `keys[2]` strobes after ticks 1, 4, 6, 8 and 10 (counted from the first tick after the press). Each strobe is 1 cycle wide.
- **Release on tick:** `key_down[0]` falls in the same cycle as a `frame_tick` that would have stepped → no strobe, FSM returns to IDLE.
- **Simultaneous keys:** press keys 0 and 2 together → identical strobe patterns on `keys[0]` and `keys[2]`.
- **Reset mid-hold:** assert `rst = 0` for 1 cycle while in REPEAT with the key still held → all outputs 0 next cycle. `key_press` re-fires 6 cycles after `rst` returns high.
